uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Serial receiver for the auxiliary UART; the receive end of the link whose transmit side drives io_uart_txd.
- Samples the asynchronous rxd pin (io_uart_rxd / io_tp2) with 16x oversampling and deframes 8N1 characters.
- Buffers received bytes in a small first-word-fall-through FIFO that the core's register/protocol logic drains.
- Runs in the 76.8 MHz core clock domain.

Parameters:
- DIV, 42, clock cycles per oversample tick; baud = f_clk/(16*DIV). 76.8 MHz gives ~115200.
- FIFO_AW, 3, log2 of FIFO depth (8 entries).

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-high reset
- rxd  input  1  asynchronous serial input, idle high
- rd_en  input  1  pop request; ignored when rd_valid=0
- rd_data  output  8  head-of-FIFO byte; valid when rd_valid=1
- rd_valid  output  1  FIFO not empty
- fifo_count  output  FIFO_AW+1  number of stored bytes
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: byte dropped, FIFO full
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, active-high). Synchronizer flops reset to 1. State=IDLE. Counters=0. FIFO empty. rd_valid=0, rd_data=0, fifo_count=0, frame_err=0, overrun=0, busy=0.
- rxd passes through a 2-flop synchronizer (rxs). All decisions use rxs.
- Tick prescaler: counts 0..DIV-1 and emits tick on DIV-1. It is held at 0 in IDLE and restarts on the cycle the start edge is detected, so timing is deterministic.
- sample_cnt (4 bit) advances on each tick. A bit is sampled when sample_cnt==7 on a tick (mid-bit).
- IDLE: rxs==0 -> START, with prescaler and sample_cnt cleared.
- START: at mid-bit, rxs==0 -> DATA with bit_cnt=0; rxs==1 -> IDLE (glitch rejected, no flag).
- DATA: every 16 ticks after the start mid-point, shift rxs into the MSB of the shift register (LSB first on the line). After bit_cnt reaches 7 -> STOP.
- STOP, at mid-bit:
  - rxs==1 and FIFO not full (or rd_en accepted this cycle) -> push byte, then IDLE.
  - rxs==1 and FIFO full with no pop -> overrun pulse, byte dropped, then IDLE.
  - rxs==0 -> frame_err pulse, byte discarded, then BREAK.
- BREAK: stay until rxs==1, then IDLE. A held-low line produces exactly one frame_err.
- Return to IDLE happens at the stop mid-point, so the next start edge may arrive half a bit early.
- Push latency: rd_valid/fifo_count update on the clk edge after the stop-bit mid-sample cycle.
- FIFO:
  - Circular buffer with FIFO_AW-bit pointers that wrap naturally.
  - rd_data is combinationally the entry at the read pointer.
  - Pop when rd_en && rd_valid.
  - Simultaneous push and pop: both occur and fifo_count is unchanged. This also holds when full, in which case no overrun.
  - Pop when empty: no effect, pointers unchanged.
- frame_err and overrun are registered, high for exactly one clk.
- Reset asserted mid-character: the character is abandoned and the FIFO is flushed. After release, a partially received frame is not recovered; the receiver resyncs on the next high-to-low edge.

Test Plan (DIV=4, bit = 64 clk):
- Send 0xA5 in 8N1 at 64 clk/bit -> rd_valid rises once, rd_data=0xA5, fifo_count=1. rd_en for 1 clk -> rd_valid=0, fifo_count=0.
- Low glitch of 20 clk on idle line -> FSM returns to IDLE, busy falls, no push, no flags. A following 0x3C is received correctly.
- Frame 0x55 with stop bit forced low, line held low 500 clk then released -> exactly one frame_err pulse, fifo_count=0. A following 0x81 is received.
- Send 9 bytes 0x00..0x08 without reading -> fifo_count=8, one overrun pulse on the 9th, rd_data sequence 0x00..0x07.
- FIFO full, assert rd_en on the cycle the 9th byte is pushed -> no overrun, fifo_count stays 8, last entry=0x08.
- Assert rst during bit 4 of a frame -> all outputs return to reset values. A next clean 0xF0 is received as 0xF0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a small
// first-word-fall-through byte FIFO drained by the core.
module uart_rx_fifo #(
  parameter int DIV     = 42,
  parameter int FIFO_AW = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rxd,
  input  logic               rd_en,
  output logic [7:0]         rd_data,
  output logic               rd_valid,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               frame_err,
  output logic               overrun,
  output logic               busy
);

  localparam int PW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic rx_meta;
  logic rxs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  state_t          state;
  state_t          state_nx;
  logic [PW-1:0]   presc;
  logic [PW-1:0]   presc_nx;
  logic [3:0]      sample_cnt;
  logic [3:0]      sample_nx;
  logic [2:0]      bit_cnt;
  logic [2:0]      bit_nx;
  logic [7:0]      shreg;
  logic [7:0]      shreg_nx;
  logic            tick;
  logic            mid;
  logic            push_req;
  logic            fe_d;

  assign tick = (presc == PW'(DIV - 1));
  assign mid  = tick && (sample_cnt == 4'd7);

  always_comb begin
    state_nx  = state;
    presc_nx  = tick ? '0 : presc + 1'b1;
    sample_nx = tick ? sample_cnt + 1'b1 : sample_cnt;
    bit_nx    = bit_cnt;
    shreg_nx  = shreg;
    push_req  = 1'b0;
    fe_d      = 1'b0;
    unique case (state)
      S_IDLE: begin
        // Prescaler parked at zero so bit timing is anchored to the edge
        presc_nx  = '0;
        sample_nx = '0;
        if (!rxs) state_nx = S_START;
      end
      S_START: begin
        if (mid) begin
          if (!rxs) begin
            state_nx = S_DATA;
            bit_nx   = '0;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (mid) begin
          shreg_nx = {rxs, shreg[7:1]};
          bit_nx   = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (mid) begin
          if (rxs) begin
            push_req = 1'b1;
            state_nx = S_IDLE;
          end else begin
            fe_d     = 1'b1;
            state_nx = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rxs) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      presc      <= '0;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
    end else begin
      state      <= state_nx;
      presc      <= presc_nx;
      sample_cnt <= sample_nx;
      bit_cnt    <= bit_nx;
      shreg      <= shreg_nx;
    end
  end

  assign busy = (state != S_IDLE);

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full;
  logic               pop;
  logic               push;
  logic               ovr_d;

  assign full  = (count == (FIFO_AW + 1)'(DEPTH));
  assign pop   = rd_en && rd_valid;
  // A pop in the same cycle frees the slot the new byte needs
  assign push  = push_req && (!full || pop);
  assign ovr_d = push_req && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= fe_d;
      overrun   <= ovr_d;
    end
  end

  assign rd_data    = mem[rd_ptr];
  assign rd_valid   = (count != '0);
  assign fifo_count = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: byte-queue model of the
// received stream, directed scenarios plus randomized traffic.
module tb_uart_rx_fifo;
  localparam int DIV   = 4;
  localparam int AW    = 3;
  localparam int BIT   = 16 * DIV;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rxd = 1'b1;
  logic          rd_en = 1'b0;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [AW:0]   fifo_count;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  uart_rx_fifo #(.DIV(DIV), .FIFO_AW(AW)) dut (
    .clk(clk),
    .rst(rst),
    .rxd(rxd),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .fifo_count(fifo_count),
    .frame_err(frame_err),
    .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit settled = 1'b0;
  byte unsigned q[$];
  int exp_fe = 0;
  int exp_ov = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
  end

  always @(negedge clk) begin
    if (settled && !rst) begin
      check("rd_valid", rd_valid, q.size() != 0);
      check("fifo_count", fifo_count, q.size());
      if (q.size() != 0) check("rd_data", rd_data, q[0]);
      check("busy idle", busy, 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic line_frame(input logic [7:0] b, input bit stop_ok,
                            input int hold);
    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rxd = b[i];
      repeat (BIT) @(posedge clk);
    end
    #1 rxd = stop_ok;
    repeat (BIT + (stop_ok ? 0 : hold)) @(posedge clk);
    #1 rxd = 1'b1;
    if (!stop_ok) repeat (8) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok,
                      input int hold);
    settled = 1'b0;
    line_frame(b, stop_ok, hold);
    if (stop_ok) begin
      if (q.size() < DEPTH) q.push_back(b);
      else exp_ov++;
    end else begin
      exp_fe++;
    end
    settled = 1'b1;
    check("frame_err pulses", fe_cnt, exp_fe);
    check("overrun pulses", ov_cnt, exp_ov);
  endtask

  task automatic pop();
    @(negedge clk);
    rd_en = 1'b1;
    @(posedge clk);
    if (q.size() > 0) void'(q.pop_front());
    #1 rd_en = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int fe0;
    logic [7:0] d;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset rd_valid", rd_valid, 0);
    check("reset rd_data", rd_data, 0);
    check("reset fifo_count", fifo_count, 0);
    check("reset busy", busy, 0);
    check("reset frame_err", frame_err, 0);
    check("reset overrun", overrun, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(20);
    settled = 1'b1;

    send(8'hA5, 1'b1, 0);
    @(negedge clk);
    check("a5 data", rd_data, 8'hA5);
    check("a5 count", fifo_count, 1);
    pop();
    @(negedge clk);
    check("a5 popped valid", rd_valid, 0);
    check("a5 popped count", fifo_count, 0);

    settled = 1'b0;
    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("glitch busy", busy, 1);
    repeat (10) @(posedge clk);
    #1 rxd = 1'b1;
    idle(100);
    settled = 1'b1;
    @(negedge clk);
    check("glitch busy falls", busy, 0);
    check("glitch no push", fifo_count, 0);
    check("glitch no fe", fe_cnt, exp_fe);
    check("glitch no ov", ov_cnt, exp_ov);
    send(8'h3C, 1'b1, 0);
    @(negedge clk);
    check("3c data", rd_data, 8'h3C);
    pop();

    fe0 = fe_cnt;
    send(8'h55, 1'b0, 500);
    @(negedge clk);
    check("break one fe", fe_cnt - fe0, 1);
    check("break count", fifo_count, 0);
    send(8'h81, 1'b1, 0);
    @(negedge clk);
    check("81 data", rd_data, 8'h81);
    pop();

    for (int i = 0; i < 9; i++) send(8'(i), 1'b1, 0);
    @(negedge clk);
    check("full count", fifo_count, 8);
    check("one overrun", ov_cnt, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("drain order", rd_data, i);
      pop();
    end

    for (int i = 0; i < 8; i++) send(8'(i), 1'b1, 0);
    fork
      send(8'h08, 1'b1, 0);
      begin
        @(posedge clk);
        repeat (610) @(posedge clk);
        #1 rd_en = 1'b1;
        @(posedge clk);
        void'(q.pop_front());
        #1 rd_en = 1'b0;
      end
    join
    @(negedge clk);
    check("push+pop count", fifo_count, 8);
    check("push+pop no ov", ov_cnt, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("push+pop order", rd_data, i + 1);
      pop();
    end

    send(8'h77, 1'b1, 0);
    settled = 1'b0;
    d = 8'h5A;
    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1 rxd = d[i];
      repeat (BIT) @(posedge clk);
    end
    #1 rxd = d[4];
    repeat (BIT / 2) @(posedge clk);
    #1 rst = 1'b1;
    rxd = 1'b1;
    q.delete();
    @(negedge clk);
    check("mid rst rd_valid", rd_valid, 0);
    check("mid rst rd_data", rd_data, 0);
    check("mid rst count", fifo_count, 0);
    check("mid rst busy", busy, 0);
    check("mid rst fe", frame_err, 0);
    check("mid rst ov", overrun, 0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    idle(BIT);
    settled = 1'b1;
    send(8'hF0, 1'b1, 0);
    @(negedge clk);
    check("f0 data", rd_data, 8'hF0);
    check("f0 count", fifo_count, 1);
    pop();

    for (int n = 0; n < 24; n++) begin
      send(8'($urandom_range(0, 255)), $urandom_range(0, 7) != 0,
           $urandom_range(0, 200));
      repeat ($urandom_range(0, (n < 12) ? 1 : 3)) pop();
      idle($urandom_range(0, 40));
    end
    while (q.size() != 0) pop();
    @(negedge clk);
    check("final empty", fifo_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
